// File: rtl/legv8_ctrl_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle control unit.
// Pure declarations; no logic, no latency, no backpressure.
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, LOAD, HALT} state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI,
    OP_LDUR, OP_STUR, OP_CBZ, OP_B, OP_ILLEGAL
  } op_e;

  localparam logic [10:0] OPC_ADD  = 11'h458;
  localparam logic [10:0] OPC_SUB  = 11'h658;
  localparam logic [10:0] OPC_AND  = 11'h450;
  localparam logic [10:0] OPC_ORR  = 11'h550;
  localparam logic [10:0] OPC_LDUR = 11'h7C2;
  localparam logic [10:0] OPC_STUR = 11'h7C0;
  localparam logic [9:0]  OPC_ADDI = 10'h244;
  localparam logic [9:0]  OPC_SUBI = 10'h344;
  localparam logic [7:0]  OPC_CBZ  = 8'hB4;
  localparam logic [5:0]  OPC_B    = 6'h05;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;

  localparam logic [1:0] RAM_SIZE_DW = 2'b11;
  localparam logic [4:0] XZR         = 5'd31;

  typedef struct packed {
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  da;
    logic [4:0]  fs;
    logic        c0;
    logic [63:0] k;
    logic        b_sel;
    logic        en_alu;
    logic        en_b;
    logic        en_addr_alu;
    logic        ram_cs;
    logic        ram_we;
    logic        ram_re;
    logic [1:0]  ram_size;
    logic        w_reg;
  } ctrl_t;

endpackage

// File: rtl/legv8_control_unit_if.sv
// Control-unit <-> datapath/ROM signal bundle; master is the control unit.
// Plain wires, no latency, no backpressure.
interface legv8_control_unit_if;
  logic [63:0] pc;
  logic [31:0] instruction;
  logic [3:0]  status;
  logic [4:0]  SA;
  logic [4:0]  SB;
  logic [4:0]  DA;
  logic [4:0]  FS;
  logic        C0;
  logic [63:0] k;
  logic        B_Sel;
  logic        EN_ALU;
  logic        EN_B;
  logic        EN_ADDR_ALU;
  logic        ram_cs;
  logic        ram_write_en;
  logic        ram_read_en;
  logic [1:0]  ramOutsize;
  logic        w_reg;
  logic        illegal;

  modport master (
    output pc, SA, SB, DA, FS, C0, k, B_Sel, EN_ALU, EN_B, EN_ADDR_ALU,
           ram_cs, ram_write_en, ram_read_en, ramOutsize, w_reg, illegal,
    input  instruction, status
  );

  modport slave (
    input  pc, SA, SB, DA, FS, C0, k, B_Sel, EN_ALU, EN_B, EN_ADDR_ALU,
           ram_cs, ram_write_en, ram_read_en, ramOutsize, w_reg, illegal,
    output instruction, status
  );
endinterface

// File: rtl/legv8_decoder.sv
// Combinational LEGv8 decode: op class, register fields, extended immediates.
// Zero latency, no backpressure.
module legv8_decoder
  import legv8_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output op_e         op,
  output logic [4:0]  rn,
  output logic [4:0]  rm,
  output logic [4:0]  rt,
  output logic [63:0] imm_k,
  output logic [63:0] br_off
);

  assign rt = ir[4:0];
  assign rn = ir[9:5];
  assign rm = ir[20:16];

  // Widest opcode fields are checked first so short prefixes never shadow them.
  always_comb begin
    op = OP_ILLEGAL;
    if      (ir[31:21] == OPC_ADD)  op = OP_ADD;
    else if (ir[31:21] == OPC_SUB)  op = OP_SUB;
    else if (ir[31:21] == OPC_AND)  op = OP_AND;
    else if (ir[31:21] == OPC_ORR)  op = OP_ORR;
    else if (ir[31:21] == OPC_LDUR) op = OP_LDUR;
    else if (ir[31:21] == OPC_STUR) op = OP_STUR;
    else if (ir[31:22] == OPC_ADDI) op = OP_ADDI;
    else if (ir[31:22] == OPC_SUBI) op = OP_SUBI;
    else if (ir[31:24] == OPC_CBZ)  op = OP_CBZ;
    else if (ir[31:26] == OPC_B)    op = OP_B;
  end

  always_comb begin
    imm_k  = '0;
    br_off = '0;
    case (op)
      OP_ADDI, OP_SUBI: imm_k  = {52'd0, ir[21:10]};
      OP_LDUR, OP_STUR: imm_k  = {{55{ir[20]}}, ir[20:12]};
      OP_CBZ:           br_off = {{43{ir[23]}}, ir[23:5], 2'b00};
      OP_B:             br_off = {{36{ir[25]}}, ir[25:0], 2'b00};
      default:          imm_k  = '0;
    endcase
  end

endmodule

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 control FSM: owns PC, fetches, decodes and issues registered control words.
// 3 cycles per instruction (LDUR 4); no backpressure, HALT on an unsupported opcode until reset.
module legv8_control_unit #(
  parameter logic [63:0] PC_RESET    = 64'h0,
  parameter logic [1:0]  RAM_SIZE_DW = legv8_ctrl_pkg::RAM_SIZE_DW
) (
  input  logic                        clock,
  input  logic                        reset,
  legv8_control_unit_if.master        cu
);
  import legv8_ctrl_pkg::*;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        illegal_q, illegal_d;
  ctrl_t       ctrl_idle;

  op_e         op;
  logic [4:0]  rn, rm, rt;
  logic [63:0] imm_k, br_off;

  // The ROM word is decoded directly in DECODE so the EXEC word can be registered on time.
  assign ir_d = (state_q == DECODE) ? cu.instruction : ir_q;

  legv8_decoder u_decoder (
    .ir     (ir_d),
    .op     (op),
    .rn     (rn),
    .rm     (rm),
    .rt     (rt),
    .imm_k  (imm_k),
    .br_off (br_off)
  );

  always_comb begin
    ctrl_idle          = '0;
    ctrl_idle.ram_size = RAM_SIZE_DW;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ctrl_d    = ctrl_idle;
    illegal_d = illegal_q;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        state_d = EXEC;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI: begin
            ctrl_d.sa     = rn;
            ctrl_d.sb     = rm;
            ctrl_d.da     = rt;
            ctrl_d.en_alu = 1'b1;
            ctrl_d.w_reg  = (rt != XZR);
            ctrl_d.c0     = (op == OP_SUB) || (op == OP_SUBI);
            case (op)
              OP_SUB, OP_SUBI: ctrl_d.fs = FS_SUB;
              OP_AND:          ctrl_d.fs = FS_AND;
              OP_ORR:          ctrl_d.fs = FS_ORR;
              default:         ctrl_d.fs = FS_ADD;
            endcase
            if (op == OP_ADDI || op == OP_SUBI) begin
              ctrl_d.b_sel = 1'b1;
              ctrl_d.k     = imm_k;
            end
          end
          OP_LDUR, OP_STUR: begin
            ctrl_d.sa          = rn;
            ctrl_d.k           = imm_k;
            ctrl_d.b_sel       = 1'b1;
            ctrl_d.fs          = FS_ADD;
            ctrl_d.en_addr_alu = 1'b1;
            ctrl_d.ram_cs      = 1'b1;
            if (op == OP_LDUR) begin
              ctrl_d.ram_re = 1'b1;
            end else begin
              ctrl_d.sb     = rt;
              ctrl_d.en_b   = 1'b1;
              ctrl_d.ram_we = 1'b1;
            end
          end
          OP_CBZ: begin
            ctrl_d.sa = XZR;
            ctrl_d.sb = rt;
            ctrl_d.fs = FS_ADD;
          end
          OP_B: ctrl_d = ctrl_idle;
          default: begin
            illegal_d = 1'b1;
            state_d   = HALT;
          end
        endcase
      end
      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_q + 64'd4;
        case (op)
          OP_LDUR: begin
            // Keep the address and read strobe up while the RAM data is written back.
            state_d      = LOAD;
            pc_d         = pc_q;
            ctrl_d       = ctrl_q;
            ctrl_d.da    = rt;
            ctrl_d.w_reg = (rt != XZR);
          end
          OP_CBZ: if (cu.status[0]) pc_d = pc_q + br_off;
          OP_B:   pc_d = pc_q + br_off;
          default: pc_d = pc_q + 64'd4;
        endcase
      end
      LOAD: begin
        state_d = FETCH;
        pc_d    = pc_q + 64'd4;
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= PC_RESET;
      ir_q      <= '0;
      ctrl_q    <= ctrl_idle;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign cu.pc          = pc_q;
  assign cu.SA          = ctrl_q.sa;
  assign cu.SB          = ctrl_q.sb;
  assign cu.DA          = ctrl_q.da;
  assign cu.FS          = ctrl_q.fs;
  assign cu.C0          = ctrl_q.c0;
  assign cu.k           = ctrl_q.k;
  assign cu.B_Sel       = ctrl_q.b_sel;
  assign cu.EN_ALU      = ctrl_q.en_alu;
  assign cu.EN_B        = ctrl_q.en_b;
  assign cu.EN_ADDR_ALU = ctrl_q.en_addr_alu;
  assign cu.ram_cs      = ctrl_q.ram_cs;
  assign cu.ram_read_en = ctrl_q.ram_re;
  assign cu.ramOutsize  = ctrl_q.ram_size;
  assign cu.illegal     = illegal_q;
  // Write strobes are masked during the reset cycle so an aborted instruction never commits.
  assign cu.w_reg        = ctrl_q.w_reg  & ~reset;
  assign cu.ram_write_en = ctrl_q.ram_we & ~reset;

endmodule

// File: tb/tb_legv8_control_unit.sv
// Directed self-checking bench for legv8_control_unit with a synchronous ROM model.
module tb_legv8_control_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [31:0] rom [bit [63:0]];

  legv8_control_unit_if cu_if ();

  legv8_control_unit #(.PC_RESET(64'h0), .RAM_SIZE_DW(2'b11)) dut (
    .clock (clock),
    .reset (reset),
    .cu    (cu_if)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    cu_if.instruction <= rom.exists(cu_if.pc) ? rom[cu_if.pc] : 32'hFFFF_FFFF;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    rom.delete(); rom[0] = 32'h8B020023;
    do_reset();
    tests_run++; if (cu_if.pc !== 64'h0) begin tests_failed++; $display("FAIL reset_pc: got %h want 0", cu_if.pc); end
    tests_run++; if (cu_if.illegal !== 1'b0) begin tests_failed++; $display("FAIL reset_illegal: got %b want 0", cu_if.illegal); end
    tests_run++; if ({cu_if.EN_ALU, cu_if.EN_B, cu_if.EN_ADDR_ALU, cu_if.ram_cs, cu_if.ram_write_en, cu_if.ram_read_en, cu_if.w_reg, cu_if.B_Sel, cu_if.C0} !== 9'b0)
      begin tests_failed++; $display("FAIL reset_strobes: got nonzero want all 0"); end
    tests_run++; if ({cu_if.SA, cu_if.SB, cu_if.DA, cu_if.FS} !== 20'b0) begin tests_failed++; $display("FAIL reset_fields: got SA=%0d SB=%0d DA=%0d FS=%b want 0", cu_if.SA, cu_if.SB, cu_if.DA, cu_if.FS); end
    tests_run++; if (cu_if.k !== 64'h0) begin tests_failed++; $display("FAIL reset_k: got %h want 0", cu_if.k); end
    tests_run++; if (cu_if.ramOutsize !== 2'b11) begin tests_failed++; $display("FAIL reset_ramoutsize: got %b want 11", cu_if.ramOutsize); end
  endtask

  task automatic test_add();
    rom.delete(); rom[0] = 32'h8B020023;
    do_reset(); step(2);
    tests_run++; if (cu_if.SA !== 5'd1) begin tests_failed++; $display("FAIL add_sa: got %0d want 1", cu_if.SA); end
    tests_run++; if (cu_if.SB !== 5'd2) begin tests_failed++; $display("FAIL add_sb: got %0d want 2", cu_if.SB); end
    tests_run++; if (cu_if.DA !== 5'd3) begin tests_failed++; $display("FAIL add_da: got %0d want 3", cu_if.DA); end
    tests_run++; if (cu_if.FS !== 5'b01000 || cu_if.C0 !== 1'b0) begin tests_failed++; $display("FAIL add_fs: got FS=%b C0=%b want 01000/0", cu_if.FS, cu_if.C0); end
    tests_run++; if (cu_if.EN_ALU !== 1'b1 || cu_if.w_reg !== 1'b1 || cu_if.B_Sel !== 1'b0) begin tests_failed++; $display("FAIL add_en: got EN_ALU=%b w_reg=%b B_Sel=%b want 1/1/0", cu_if.EN_ALU, cu_if.w_reg, cu_if.B_Sel); end
    step(1);
    tests_run++; if (cu_if.pc !== 64'd4) begin tests_failed++; $display("FAIL add_pc: got %h want 4", cu_if.pc); end
    tests_run++; if (cu_if.EN_ALU !== 1'b0 || cu_if.w_reg !== 1'b0) begin tests_failed++; $display("FAIL add_fetch_idle: got EN_ALU=%b w_reg=%b want 0/0", cu_if.EN_ALU, cu_if.w_reg); end
  endtask

  task automatic test_addi_subi();
    rom.delete(); rom[0] = 32'h913FFC05; rom[4] = 32'hD1000405;
    do_reset(); step(2);
    tests_run++; if (cu_if.k !== 64'h0000_0000_0000_0FFF) begin tests_failed++; $display("FAIL addi_k: got %h want 0fff", cu_if.k); end
    tests_run++; if (cu_if.B_Sel !== 1'b1 || cu_if.FS !== 5'b01000 || cu_if.C0 !== 1'b0) begin tests_failed++; $display("FAIL addi_ctl: got B_Sel=%b FS=%b C0=%b want 1/01000/0", cu_if.B_Sel, cu_if.FS, cu_if.C0); end
    tests_run++; if (cu_if.DA !== 5'd5 || cu_if.SA !== 5'd0 || cu_if.w_reg !== 1'b1) begin tests_failed++; $display("FAIL addi_regs: got DA=%0d SA=%0d w_reg=%b want 5/0/1", cu_if.DA, cu_if.SA, cu_if.w_reg); end
    step(3);
    tests_run++; if (cu_if.FS !== 5'b01001 || cu_if.C0 !== 1'b1) begin tests_failed++; $display("FAIL subi_fs: got FS=%b C0=%b want 01001/1", cu_if.FS, cu_if.C0); end
    tests_run++; if (cu_if.k !== 64'd1 || cu_if.B_Sel !== 1'b1) begin tests_failed++; $display("FAIL subi_k: got k=%h B_Sel=%b want 1/1", cu_if.k, cu_if.B_Sel); end
    step(1);
    tests_run++; if (cu_if.pc !== 64'd8) begin tests_failed++; $display("FAIL subi_pc: got %h want 8", cu_if.pc); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_fs [3];
    logic       exp_c0 [3];
    rom.delete(); rom[0] = 32'hCB020023; rom[4] = 32'h8A020023; rom[8] = 32'hAA020023;
    exp_fs[0] = 5'b01001; exp_c0[0] = 1'b1;
    exp_fs[1] = 5'b00000; exp_c0[1] = 1'b0;
    exp_fs[2] = 5'b00100; exp_c0[2] = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(2);
      tests_run++; if (cu_if.FS !== exp_fs[i] || cu_if.C0 !== exp_c0[i]) begin tests_failed++; $display("FAIL b2b_fs%0d: got FS=%b C0=%b want %b/%b", i, cu_if.FS, cu_if.C0, exp_fs[i], exp_c0[i]); end
      step(1);
      tests_run++; if (cu_if.pc !== 64'(4 * (i + 1))) begin tests_failed++; $display("FAIL b2b_pc%0d: got %h want %h", i, cu_if.pc, 4 * (i + 1)); end
    end
  endtask

  task automatic test_load();
    logic [1:0] ovl;
    rom.delete(); rom[0] = 32'hF85F8047;
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      ovl = 2'(cu_if.EN_ALU) + 2'(cu_if.EN_B) + 2'(cu_if.ram_read_en);
      tests_run++; if (ovl > 2'd1) begin tests_failed++; $display("FAIL ldur_bus_c%0d: got %0d drivers want <=1", c, ovl); end
      if (c == 3) begin
        tests_run++; if (cu_if.k !== 64'hFFFF_FFFF_FFFF_FFF8) begin tests_failed++; $display("FAIL ldur_k: got %h want fffffffffffffff8", cu_if.k); end
        tests_run++; if (cu_if.ram_read_en !== 1'b1 || cu_if.EN_ADDR_ALU !== 1'b1 || cu_if.ram_cs !== 1'b1) begin tests_failed++; $display("FAIL ldur_exec_strobes: got re=%b addr=%b cs=%b want 1/1/1", cu_if.ram_read_en, cu_if.EN_ADDR_ALU, cu_if.ram_cs); end
        tests_run++; if (cu_if.SA !== 5'd2 || cu_if.FS !== 5'b01000 || cu_if.B_Sel !== 1'b1 || cu_if.w_reg !== 1'b0) begin tests_failed++; $display("FAIL ldur_exec_ctl: got SA=%0d FS=%b B_Sel=%b w_reg=%b want 2/01000/1/0", cu_if.SA, cu_if.FS, cu_if.B_Sel, cu_if.w_reg); end
      end
      if (c == 4) begin
        tests_run++; if (cu_if.DA !== 5'd7 || cu_if.w_reg !== 1'b1) begin tests_failed++; $display("FAIL ldur_load_wb: got DA=%0d w_reg=%b want 7/1", cu_if.DA, cu_if.w_reg); end
        tests_run++; if (cu_if.ram_read_en !== 1'b1 || cu_if.k !== 64'hFFFF_FFFF_FFFF_FFF8) begin tests_failed++; $display("FAIL ldur_load_hold: got re=%b k=%h want 1/fffffffffffffff8", cu_if.ram_read_en, cu_if.k); end
        tests_run++; if (cu_if.pc !== 64'h0) begin tests_failed++; $display("FAIL ldur_load_pc: got %h want 0", cu_if.pc); end
      end
      if (c == 5) begin
        tests_run++; if (cu_if.pc !== 64'd4 || cu_if.ram_read_en !== 1'b0) begin tests_failed++; $display("FAIL ldur_done: got pc=%h re=%b want 4/0", cu_if.pc, cu_if.ram_read_en); end
      end
      step(1);
    end
  endtask

  task automatic test_store();
    rom.delete(); rom[0] = 32'hF8010069;
    do_reset(); step(2);
    tests_run++; if (cu_if.SA !== 5'd3 || cu_if.SB !== 5'd9 || cu_if.k !== 64'd16) begin tests_failed++; $display("FAIL stur_fields: got SA=%0d SB=%0d k=%h want 3/9/10", cu_if.SA, cu_if.SB, cu_if.k); end
    tests_run++; if (cu_if.EN_B !== 1'b1 || cu_if.ram_write_en !== 1'b1 || cu_if.ram_cs !== 1'b1 || cu_if.EN_ADDR_ALU !== 1'b1) begin tests_failed++; $display("FAIL stur_strobes: got EN_B=%b we=%b cs=%b addr=%b want 1/1/1/1", cu_if.EN_B, cu_if.ram_write_en, cu_if.ram_cs, cu_if.EN_ADDR_ALU); end
    tests_run++; if (cu_if.ram_read_en !== 1'b0 || cu_if.EN_ALU !== 1'b0 || cu_if.w_reg !== 1'b0) begin tests_failed++; $display("FAIL stur_quiet: got re=%b EN_ALU=%b w_reg=%b want 0/0/0", cu_if.ram_read_en, cu_if.EN_ALU, cu_if.w_reg); end
    step(1);
    tests_run++; if (cu_if.pc !== 64'd4 || cu_if.ram_write_en !== 1'b0) begin tests_failed++; $display("FAIL stur_pc: got pc=%h we=%b want 4/0", cu_if.pc, cu_if.ram_write_en); end
  endtask

  task automatic test_cbz(input logic [3:0] st, input logic [63:0] exp_pc);
    rom.delete(); rom[0] = 32'h14000010; rom[64'h40] = 32'hB4FFFFC4;
    cu_if.status = st;
    do_reset(); step(3);
    tests_run++; if (cu_if.pc !== 64'h40) begin tests_failed++; $display("FAIL b_fwd_pc: got %h want 40", cu_if.pc); end
    step(2);
    tests_run++; if (cu_if.SA !== 5'd31 || cu_if.SB !== 5'd4 || cu_if.FS !== 5'b01000 || cu_if.B_Sel !== 1'b0) begin tests_failed++; $display("FAIL cbz_ctl: got SA=%0d SB=%0d FS=%b B_Sel=%b want 31/4/01000/0", cu_if.SA, cu_if.SB, cu_if.FS, cu_if.B_Sel); end
    step(1);
    tests_run++; if (cu_if.pc !== exp_pc) begin tests_failed++; $display("FAIL cbz_pc_st%b: got %h want %h", st, cu_if.pc, exp_pc); end
    cu_if.status = 4'b0000;
  endtask

  task automatic test_branch_wrap();
    rom.delete(); rom[0] = 32'h17FFFFFF;
    do_reset(); step(3);
    tests_run++; if (cu_if.pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin tests_failed++; $display("FAIL b_wrap_pc: got %h want fffffffffffffffc", cu_if.pc); end
  endtask

  task automatic test_illegal();
    rom.delete(); rom[0] = 32'h8B020023; rom[4] = 32'hFFFFFFFF;
    do_reset(); step(5);
    tests_run++; if (cu_if.illegal !== 1'b1) begin tests_failed++; $display("FAIL illegal_set: got %b want 1", cu_if.illegal); end
    tests_run++; if (cu_if.EN_ALU !== 1'b0 || cu_if.w_reg !== 1'b0) begin tests_failed++; $display("FAIL illegal_idle: got EN_ALU=%b w_reg=%b want 0/0", cu_if.EN_ALU, cu_if.w_reg); end
    step(4);
    tests_run++; if (cu_if.pc !== 64'd4 || cu_if.illegal !== 1'b1) begin tests_failed++; $display("FAIL halt_frozen: got pc=%h illegal=%b want 4/1", cu_if.pc, cu_if.illegal); end
    do_reset();
    tests_run++; if (cu_if.pc !== 64'h0 || cu_if.illegal !== 1'b0) begin tests_failed++; $display("FAIL halt_reset: got pc=%h illegal=%b want 0/0", cu_if.pc, cu_if.illegal); end
  endtask

  task automatic test_xzr_dest();
    rom.delete(); rom[0] = 32'h8B02003F;
    do_reset(); step(2);
    tests_run++; if (cu_if.w_reg !== 1'b0 || cu_if.EN_ALU !== 1'b1 || cu_if.DA !== 5'd31) begin tests_failed++; $display("FAIL xzr_wreg: got w_reg=%b EN_ALU=%b DA=%0d want 0/1/31", cu_if.w_reg, cu_if.EN_ALU, cu_if.DA); end
  endtask

  task automatic test_reset_in_load();
    rom.delete(); rom[0] = 32'hF85F8047;
    do_reset(); step(3);
    tests_run++; if (cu_if.w_reg !== 1'b1) begin tests_failed++; $display("FAIL rld_pre: got w_reg=%b want 1", cu_if.w_reg); end
    reset = 1'b1; #1;
    tests_run++; if (cu_if.w_reg !== 1'b0) begin tests_failed++; $display("FAIL rld_no_write: got w_reg=%b want 0", cu_if.w_reg); end
    @(negedge clock); reset = 1'b0;
    tests_run++; if (cu_if.pc !== 64'h0 || cu_if.ram_read_en !== 1'b0 || cu_if.w_reg !== 1'b0 || cu_if.DA !== 5'd0) begin tests_failed++; $display("FAIL rld_after: got pc=%h re=%b w_reg=%b DA=%0d want 0/0/0/0", cu_if.pc, cu_if.ram_read_en, cu_if.w_reg, cu_if.DA); end
    step(2);
    tests_run++; if (cu_if.ram_read_en !== 1'b1 || cu_if.w_reg !== 1'b0) begin tests_failed++; $display("FAIL rld_restart: got re=%b w_reg=%b want 1/0", cu_if.ram_read_en, cu_if.w_reg); end
  endtask

  initial begin
    cu_if.status = 4'b0000;
    test_reset();
    test_add();
    test_addi_subi();
    test_back_to_back();
    test_load();
    test_store();
    test_cbz(4'b0001, 64'h38);
    test_cbz(4'b0000, 64'h44);
    test_branch_wrap();
    test_illegal();
    test_xzr_dest();
    test_reset_in_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/legv8_control_unit.md
Name: legv8_control_unit

Overview:
- Multi-cycle control FSM for the 64-bit LEGv8 datapath. It owns the PC, fetches instruction words from a synchronous instruction ROM, and decodes them.
- Each instruction is sequenced as per-cycle control words: SA/SB/DA, FS, C0, k, B_Sel, bus enables and RAM strobes. These words drive the datapath's register file, ALU, tri-state bus and RAM.
- The datapath responds. This block is the initiator on that control interface and closes the loop through the ALU status flags.

Parameters:
- PC_RESET, 64'h0, PC value loaded on reset.
- RAM_SIZE_DW, 2'b11, ramOutsize code for a 64-bit doubleword access.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- pc  out  64  instruction ROM address.
- instruction  in  32  ROM data, valid the cycle after pc is presented.
- status  in  4  ALU flags {V,C,N,Z}; Z = status[0].
- SA, SB, DA  out  5 each  register selects.
- FS  out  5  ALU function code.
- C0  out  1  ALU carry-in.
- k  out  64  immediate/constant to the datapath mux.
- B_Sel  out  1  1 = use k as the ALU B input.
- EN_ALU, EN_B, EN_ADDR_ALU  out  1 each  tri-state enables.
- ram_cs, ram_write_en, ram_read_en  out  1 each  RAM strobes.
- ramOutsize  out  2  RAM access size.
- w_reg  out  1  register-file write enable.
- illegal  out  1  sticky: an unsupported opcode was decoded.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Reset:
  - pc = PC_RESET; state = FETCH; illegal = 0.
  - All enables, strobes, w_reg, B_Sel and C0 = 0; SA, SB, DA, FS, k = 0; ramOutsize = RAM_SIZE_DW.
  - Reset in any state aborts the instruction at the next edge. No write is issued in the reset cycle.
- Default control word (every state unless stated otherwise): same values as at reset.
- Bus rule: at most one of EN_ALU, EN_B and ram_read_en may be high in any cycle.
- States:
  - FETCH: present pc. Go to DECODE.
  - DECODE: latch instruction into IR and decode, selecting by the top 6/8/10/11 opcode bits.
    - Unsupported opcode: illegal = 1, go to HALT.
  - EXEC:
    - R-type ADD/SUB/AND/ORR: SA = Rn, SB = Rm, DA = Rd, B_Sel = 0, EN_ALU = 1, w_reg = (Rd != 31). pc += 4. Go to FETCH.
    - ADDI/SUBI: B_Sel = 1, k = zero-extended imm12 (IR[21:10]). Otherwise as R-type.
    - LDUR: SA = Rn, k = sign-extended IR[20:12], B_Sel = 1, FS = ADD, EN_ADDR_ALU = 1, ram_cs = 1, ram_read_en = 1. Go to LOAD.
    - STUR: same address generation, plus SB = Rt, EN_B = 1, ram_cs = 1, ram_write_en = 1. pc += 4. Go to FETCH.
    - CBZ: SA = 31, SB = Rt, FS = ADD, B_Sel = 0.
      - Z = 1: pc += sext(IR[23:5]) << 2.
      - Z = 0: pc += 4.
      - Go to FETCH.
    - B: pc += sext(IR[25:0]) << 2. Go to FETCH.
  - LOAD: hold the LDUR address and ram_cs/ram_read_en; DA = Rt; w_reg = (Rt != 31). pc += 4. Go to FETCH.
  - HALT: default control word, pc frozen. Exit only on reset.
- Latency: R-type/I-type/STUR/CBZ/B take 3 cycles; LDUR takes 4.
- FS codes (FS[4:2] = op, FS[1] = invert A, FS[0] = invert B):
  - AND = 5'b00000; ORR = 5'b00100; ADD = 5'b01000 with C0 = 0; SUB = 5'b01001 with C0 = 1.
- PC arithmetic: 64-bit, wraps modulo 2^64. Branch offsets are two's complement, so a negative displacement from pc = 0 wraps.
- Opcodes (hex of leading bits):
  - ADD 0x458, SUB 0x658, AND 0x450, ORR 0x550 (11 bits).
  - ADDI 0x244, SUBI 0x344 (10 bits).
  - LDUR 0x7C2, STUR 0x7C0 (11 bits).
  - CBZ 0xB4 (8 bits).
  - B 0x05 (6 bits).

Decomposition:
- Package legv8_ctrl_pkg: state enum (FETCH, DECODE, EXEC, LOAD, HALT), opcode constants, FS constants, RAM_SIZE_DW.
- Sub-module legv8_decoder: combinational. Maps IR to op class, register fields and extended immediate.
- The FSM, PC register and control-word register live in the top module.

Test Plan:
- Reset then ADD X3,X1,X2 (0x8B020023) → cycle 3: SA=1, SB=2, DA=3, FS=01000, EN_ALU=1, w_reg=1; pc=4 in the next FETCH.
- ADDI X5,X0,#0xFFF → k=64'h0000_0000_0000_0FFF, B_Sel=1; SUBI gives FS=01001, C0=1.
- LDUR X7,[X2,#-8] → EXEC: k=64'hFFFF_FFFF_FFFF_FFF8, ram_read_en=1, EN_ADDR_ALU=1; LOAD: DA=7, w_reg=1; 4 cycles total; EN_ALU, EN_B and ram_read_en never overlap.
- CBZ X4,#-2 at pc=0x40:
  - status=4'b0001 → pc=0x38.
  - status=4'b0000 → pc=0x44.
- Opcode 0xFFFFFFFF → illegal=1, HALT, pc frozen; assert reset in HALT → pc=PC_RESET, illegal=0.
- ADD X31,X1,X2 → w_reg stays 0; reset asserted during LOAD → no w_reg pulse, state FETCH, pc=PC_RESET.
